conv_line_loader: RTL and testbench

- Receive side of the engine's DDR pixel path. Consumes 24-bit packed RGB words read from DDR and stores them in ROWS circular line buffers of LINE_W pixels each.
- Once ROWS-1 rows are primed, each accepted word produces one ROWS-tall pixel column per channel. The column feeds the per-channel 5x5 convolution window shift registers.
- It mirrors the engine's output packer, which splits 3-channel results back into 24-bit DDR words.

---
 rtl/conv_line_loader.sv | 113 +++++++++++
 tb/tb_conv_line_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_line_loader.sv
// rtl/conv_line_loader.sv - DDR pixel line-buffer loader emitting ROWS-tall per-channel columns
module conv_line_loader #(
  parameter int LINE_W = 45,
  parameter int ROWS   = 5,
  parameter int PX_W   = 8
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic [3*PX_W-1:0]      ddr_rval,
  input  logic                   ddr_rvalid,
  output logic                   ddr_rready,
  input  logic                   frame_start,
  output logic [3*ROWS*PX_W-1:0] col_out,
  output logic                   col_valid,
  input  logic                   col_ready,
  output logic [5:0]             col_x,
  output logic [15:0]            row_y,
  output logic                   primed
);

  localparam int             WORD_W   = 3 * PX_W;
  localparam logic [5:0]     X_LAST   = 6'(LINE_W - 1);
  localparam logic [2:0]     ROW_LAST = 3'(ROWS - 1);

  logic [WORD_W-1:0]        line_buf [ROWS][LINE_W];
  logic [5:0]               x;
  logic [2:0]               wr_row;
  logic [2:0]               rows_done;
  logic [15:0]              y;
  logic                     accept;
  logic                     emit;
  logic [5:0]               wr_x;
  logic [2:0]               wr_sel;
  logic [3*ROWS*PX_W-1:0]   col_next;
  logic [3:0]               rd_sum;
  logic [2:0]               rd_row;
  logic [WORD_W-1:0]        rd_word;

  // Single output slot: a new word may enter whenever the slot is empty or being drained.
  assign ddr_rready = !col_valid || col_ready;
  assign accept     = ddr_rvalid && ddr_rready;
  assign primed     = (rows_done == ROW_LAST);
  assign emit       = accept && primed && !frame_start;

  // A frame_start word lands as pixel (0,0) of the new frame.
  assign wr_x   = frame_start ? 6'd0 : x;
  assign wr_sel = frame_start ? 3'd0 : wr_row;

  // Assemble the column: older rows come from the buffers, the newest row is the incoming word.
  always_comb begin
    col_next = '0;
    rd_sum   = '0;
    rd_row   = '0;
    rd_word  = '0;
    for (int r = 0; r < ROWS; r++) begin
      rd_sum = {1'b0, wr_row} + 4'd1 + 4'(r);
      if (rd_sum >= 4'(ROWS)) rd_sum = rd_sum - 4'(ROWS);
      rd_row = rd_sum[2:0];
      if (r == ROWS - 1) rd_word = ddr_rval;
      else               rd_word = line_buf[rd_row][x];
      for (int c = 0; c < 3; c++) begin
        col_next[(c*ROWS + r)*PX_W +: PX_W] = rd_word[c*PX_W +: PX_W];
      end
    end
  end

  // Line-buffer storage; contents survive reset and are simply overwritten by the next frame.
  always_ff @(posedge CLK) begin
    if (RESETN && accept) line_buf[wr_sel][wr_x] <= ddr_rval;
  end

  // Position counters, priming progress and the registered output column.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      x         <= '0;
      wr_row    <= '0;
      rows_done <= '0;
      y         <= '0;
      col_valid <= 1'b0;
      col_out   <= '0;
      col_x     <= '0;
      row_y     <= '0;
    end else begin
      if (frame_start) begin
        x         <= accept ? 6'd1 : 6'd0;
        wr_row    <= '0;
        y         <= '0;
        rows_done <= '0;
      end else if (accept) begin
        if (x == X_LAST) begin
          x      <= '0;
          wr_row <= (wr_row == ROW_LAST) ? 3'd0 : wr_row + 3'd1;
          if (y != 16'hFFFF)        y         <= y + 16'd1;
          if (rows_done != ROW_LAST) rows_done <= rows_done + 3'd1;
        end else begin
          x <= x + 6'd1;
        end
      end

      if (frame_start) begin
        col_valid <= 1'b0;
      end else if (emit) begin
        col_valid <= 1'b1;
        col_out   <= col_next;
        col_x     <= x;
        row_y     <= y;
      end else if (col_ready) begin
        col_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_line_loader.sv
// tb/tb_conv_line_loader.sv - directed self-checking bench for conv_line_loader
module tb_conv_line_loader;

  localparam int LINE_W = 45;
  localparam int ROWS   = 5;
  localparam int PX_W   = 8;

  logic           CLK;
  logic           RESETN;
  logic [23:0]    ddr_rval;
  logic           ddr_rvalid;
  logic           ddr_rready;
  logic           frame_start;
  logic [119:0]   col_out;
  logic           col_valid;
  logic           col_ready;
  logic [5:0]     col_x;
  logic [15:0]    row_y;
  logic           primed;

  int checks   = 0;
  int failures = 0;

  conv_line_loader #(.LINE_W(LINE_W), .ROWS(ROWS), .PX_W(PX_W)) dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .ddr_rval   (ddr_rval),
    .ddr_rvalid (ddr_rvalid),
    .ddr_rready (ddr_rready),
    .frame_start(frame_start),
    .col_out    (col_out),
    .col_valid  (col_valid),
    .col_ready  (col_ready),
    .col_x      (col_x),
    .row_y      (row_y),
    .primed     (primed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [23:0] pix(input int yy, input int xx);
    return {8'(yy), 8'(xx), 8'(yy + xx)};
  endfunction

  // Column expected for newest frame row ny at column cx: rows ny-4..ny, oldest first.
  function automatic logic [119:0] exp_col(input int ny, input int cx);
    logic [119:0] v;
    int yy;
    v = '0;
    for (int r = 0; r < 5; r++) begin
      yy = ny - 4 + r;
      v[(10 + r)*8 +: 8] = 8'(yy);
      v[(5 + r)*8 +: 8]  = 8'(cx);
      v[r*8 +: 8]        = 8'(yy + cx);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int yy, input int xx);
    ddr_rval   = pix(yy, xx);
    ddr_rvalid = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Stream frame-relative linear indices i0..i1, counting any deviation from the expected outputs.
  task automatic stream(input int i0, input int i1, output int bad);
    bit ev;
    bad = 0;
    for (int i = i0; i <= i1; i++) begin
      send(i / LINE_W, i % LINE_W);
      ev = (i >= 4 * LINE_W);
      if (col_valid !== ev) bad++;
      if (primed !== (i >= 4 * LINE_W - 1)) bad++;
      if (ev && (col_out !== exp_col(i / LINE_W, i % LINE_W) ||
                 col_x !== 6'(i % LINE_W) || row_y !== 16'(i / LINE_W))) bad++;
    end
  endtask

  task automatic prime_and_first(input string pfx);
    int bad;
    stream(0, 4*LINE_W - 2, bad);
    chk({pfx, "_prime_stream"}, 128'(bad), 128'(0));
    chk({pfx, "_primed_before_last"}, 128'(primed), 128'(1'b0));
    send(3, 44);
    chk({pfx, "_primed_after_180"}, 128'(primed), 128'(1'b1));
    chk({pfx, "_no_col_at_180"}, 128'(col_valid), 128'(1'b0));
    send(4, 0);
    chk({pfx, "_first_valid"}, 128'(col_valid), 128'(1'b1));
    chk({pfx, "_first_x"}, 128'(col_x), 128'(0));
    chk({pfx, "_first_y"}, 128'(row_y), 128'(4));
    chk({pfx, "_first_col"}, 128'(col_out), 128'(exp_col(4, 0)));
  endtask

  initial begin
    int bad;
    RESETN      = 1'b0;
    ddr_rval    = '0;
    ddr_rvalid  = 1'b0;
    frame_start = 1'b0;
    col_ready   = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_col_valid", 128'(col_valid), 128'(1'b0));
    chk("rst_col_out", 128'(col_out), 128'(0));
    chk("rst_col_x", 128'(col_x), 128'(0));
    chk("rst_row_y", 128'(row_y), 128'(0));
    chk("rst_primed", 128'(primed), 128'(1'b0));
    chk("rst_rready", 128'(ddr_rready), 128'(1'b1));
    RESETN = 1'b1;
    @(posedge CLK);
    #1;

    // Priming and first column
    prime_and_first("p1");

    // Backpressure at y=4, x=7
    stream(4*LINE_W + 1, 4*LINE_W + 7, bad);
    chk("pre_bp_stream", 128'(bad), 128'(0));
    col_ready  = 1'b0;
    ddr_rval   = pix(4, 8);
    ddr_rvalid = 1'b1;
    #1;
    chk("bp_rready_low", 128'(ddr_rready), 128'(1'b0));
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK);
      #1;
      if (ddr_rready !== 1'b0 || col_valid !== 1'b1 || col_x !== 6'd7 ||
          row_y !== 16'd4 || col_out !== exp_col(4, 7)) bad++;
    end
    chk("bp_hold_10", 128'(bad), 128'(0));
    col_ready = 1'b1;
    #1;
    chk("bp_release_rready", 128'(ddr_rready), 128'(1'b1));
    @(posedge CLK);
    #1;
    chk("bp_next_x", 128'(col_x), 128'(8));
    chk("bp_next_col", 128'(col_out), 128'(exp_col(4, 8)));

    // frame_start mid-row at y=5, x=20 with a word
    stream(4*LINE_W + 9, 5*LINE_W + 19, bad);
    chk("pre_fs_stream", 128'(bad), 128'(0));
    chk("pre_fs_valid", 128'(col_valid), 128'(1'b1));
    frame_start = 1'b1;
    send(0, 0);
    frame_start = 1'b0;
    chk("fs_col_valid", 128'(col_valid), 128'(1'b0));
    chk("fs_primed", 128'(primed), 128'(1'b0));
    stream(1, 4*LINE_W - 1, bad);
    chk("fs_reprime_stream", 128'(bad), 128'(0));
    send(4, 0);
    chk("fs_first_valid", 128'(col_valid), 128'(1'b1));
    chk("fs_first_y", 128'(row_y), 128'(4));
    chk("fs_first_x", 128'(col_x), 128'(0));
    chk("fs_first_col", 128'(col_out), 128'(exp_col(4, 0)));

    // Buffer wrap through y=6, x=44
    stream(4*LINE_W + 1, 6*LINE_W + 44, bad);
    chk("wrap_stream", 128'(bad), 128'(0));
    chk("wrap_x", 128'(col_x), 128'(44));
    chk("wrap_y", 128'(row_y), 128'(6));
    chk("wrap_col", 128'(col_out), 128'(exp_col(6, 44)));
    send(7, 0);
    chk("wrap_next_x", 128'(col_x), 128'(0));
    chk("wrap_next_y", 128'(row_y), 128'(7));
    chk("wrap_next_col", 128'(col_out), 128'(exp_col(7, 0)));

    // Asynchronous reset with a column pending
    ddr_rvalid = 1'b0;
    #2;
    chk("ar_pre_valid", 128'(col_valid), 128'(1'b1));
    RESETN = 1'b0;
    #1;
    chk("ar_col_valid", 128'(col_valid), 128'(1'b0));
    chk("ar_col_x", 128'(col_x), 128'(0));
    chk("ar_row_y", 128'(row_y), 128'(0));
    chk("ar_primed", 128'(primed), 128'(1'b0));
    chk("ar_col_out", 128'(col_out), 128'(0));
    repeat (2) @(posedge CLK);
    #1;
    RESETN = 1'b1;
    @(posedge CLK);
    #1;
    prime_and_first("p2");

    ddr_rvalid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
